jpeg_rld: RTL
=============

// Module: jpeg_rld
// PURPOSE
//  JPEG run-length decoder, the inverse of the RLE encoder path.
//  - Consumes (rlen, size, amp) tokens, with bstart marking each block's DC token.
//  - Expands ZRL (15,0) and EOB (0,0) tokens.
//  - Emits 64 zig-zag-ordered 11-bit coefficients per block, one per enabled cycle.
//  - Sits between the Huffman decoder and the de-zigzag/dequantiser in the decode pipeline.
// PARAMETERS
//  BLOCK_LEN  64  coefficients per block; must be a power of two
//  DW         11  output coefficient width (two's complement)
//  AW         12  input amplitude width (two's complement, sign-extended)
// PORTS
//  clk     in   1   system clock
//  rst     in   1   asynchronous reset, active-low
//  ena     in   1   clock enable; when low, all state, outputs and counters hold
//  den     in   1   input token valid
//  bstart  in   1   token is the DC term of a new block (qualified by den)
//  rlen    in   4   zero-run preceding the coefficient
//  size    in   4   amplitude category; 0 marks EOB or ZRL
//  amp     in   AW  coefficient amplitude
//  rdy     out  1   token accepted on the cycle where den && rdy && ena
//  dout    out  DW  coefficient, amp[DW-1:0] or zero
//  dval    out  1   dout valid
//  dstrb   out  1   first coefficient of a block (index 0)
//  dlast   out  1   last coefficient of a block (index BLOCK_LEN-1)
//  err     out  1   one-cycle protocol-error pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset
//  - rst=0 forces state IDLE, idx=0 and the run counter to 0.
//  - dout=0, dval=0, dstrb=0, dlast=0, err=0. rdy reads 1 after reset.
//  States: IDLE, RUN, COEF, FILL. Counter idx runs 0..BLOCK_LEN-1.
//  IDLE
//  - Non-bstart tokens are accepted and dropped; err pulses.
//  - A bstart token is accepted and loads run=rlen. If rlen=0 -> COEF, else -> RUN.
//  RUN: emit one zero per cycle and decrement run; at run=0 -> COEF.
//  COEF: emit amp. Then:
//  - idx=63 -> IDLE.
//  - A new token is pending -> decode it in the same cycle (no bubble).
//  - Otherwise wait in COEF-idle (dval=0).
//  Token classification (AC tokens)
//  - size=0, rlen=0: EOB. Go to FILL, emitting zeros until idx=63, then IDLE.
//    EOB at idx 63 (block already full) is accepted without output.
//  - size=0, rlen=15: ZRL. Emit 16 zeros, with no amplitude emitted.
//  - size=0 with any other rlen: treated as ZRL of rlen+1 zeros; err pulses.
//  Latency: token accepted in cycle N -> its first output in cycle N+1.
//  rdy
//  - High when IDLE or COEF-idle.
//  - Also high during the cycle that emits the final output of the current token.
//  - Result: back-to-back rlen=0 tokens stream at 1 coef/cycle.
//  Overflow: a run that would cross idx 63 is truncated at 63; the block ends; err pulses.
//  A bstart token mid-block (before dlast)
//  - The current block is abandoned without fill; err pulses.
//  - The new token starts a block at idx=0. dstrb marks it.
//  dlast and dstrb are coincident only if BLOCK_LEN=1; this configuration is unsupported.
//  Arithmetic
//  - idx increments modulo BLOCK_LEN.
//  - amp is truncated to DW bits. Upper bits are not checked unless the macro is set.
// CONFIGURATION
//  JPEG_RLD_ERR_EN defined
//  - err pulses on: orphan AC token, illegal size=0 token, overflow, mid-block bstart.
//  - err also pulses when amp[AW-1:DW] is not a sign extension.
//  JPEG_RLD_ERR_EN undefined
//  - err is tied to 0.
//  - Recovery behaviour (truncate, drop, restart) is identical in both builds.
// STRUCTURE
//  Package jpeg_rld_pkg holds:
//  - state enum (IDLE, RUN, COEF, FILL)
//  - BLOCK_LEN_DEF=64
//  - RLEN_ZRL=4'hf
//  - token type enum (DC, AC, ZRL, EOB, BAD)
//  - function classify_token(bstart, rlen, size)
//  Sub-module jpeg_rld_tok
//  - One-entry token register.
//  - Holds the accepted token with its classification and decouples rdy from the den path.
//  The top level holds the FSM, the idx/run counters and the output registers.
// TESTING
//  1. DC-only block: {bstart,r0,s3,amp=5}, then (0,0).
//     -> 5, then 63 zeros; dstrb on 5; dlast on the 64th output; err=0.
//  2. AC runs: DC=-3, {r2,s2,amp=2}, EOB.
//     -> -3,0,0,2 then 60 zeros; coef 2 at idx 3.
//  3. ZRL: DC=1, (15,0), (15,0), {r3,s1,amp=-1}, EOB.
//     -> idx 36 = -1, all other AC = 0, 64 outputs total.
//  4. Full block: 64 back-to-back rlen=0 tokens (amp=idx+1), den held high.
//     -> rdy never low; 64 consecutive dval cycles; then IDLE.
//  5. Error paths, with JPEG_RLD_ERR_EN defined:
//     - {r15,s1} at idx 60 -> truncated at 63, one err pulse.
//     - bstart at idx 10 -> err pulse and new block at idx 0.
//     Without the macro: same dout sequence, err=0.
//  6. ena low 5 cycles mid-RUN -> outputs and idx frozen, sequence resumes unchanged.
//     rst low mid-block -> all outputs 0; the next bstart token starts a clean block.

Source files
------------

// File: rtl/jpeg_rld_pkg.sv
// Shared types for the JPEG run-length decoder: FSM states, token classes and the token classifier.
package jpeg_rld_pkg;

    localparam int         BLOCK_LEN_DEF = 64;
    localparam logic [3:0] RLEN_ZRL      = 4'hf;

    typedef enum logic [1:0] {IDLE, RUN, COEF, FILL} state_t;
    typedef enum logic [2:0] {DC, AC, ZRL, EOB, BAD} tok_t;

    function automatic tok_t classify_token(input logic bstart, input logic [3:0] rlen,
                                            input logic [3:0] size);
        if (bstart)            return DC;
        if (size != 4'd0)      return AC;
        if (rlen == 4'd0)      return EOB;
        if (rlen == RLEN_ZRL)  return ZRL;
        return BAD;
    endfunction

endpackage

// File: rtl/jpeg_rld_tok.sv
// One-entry token register: classifies the incoming token and holds its amplitude while its run drains.
module jpeg_rld_tok
    import jpeg_rld_pkg::*;
#(
    parameter int DW = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ena,
    input  logic          i_load,
    input  logic          i_bstart,
    input  logic [3:0]    i_rlen,
    input  logic [3:0]    i_size,
    input  logic [DW-1:0] i_amp,
    input  logic          i_trunc,
    output logic [2:0]    o_type,
    output logic [DW-1:0] o_amp,
    output logic          o_has_amp
);

    tok_t          w_type;
    logic          w_has_amp;
    logic [DW-1:0] r_amp;
    logic          r_has_amp;

    assign w_type    = classify_token(i_bstart, i_rlen, i_size);
    // A truncated run loses its amplitude: the block ends before it is reached.
    assign w_has_amp = ((w_type == DC) || (w_type == AC)) && !i_trunc;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_amp     <= '0;
            r_has_amp <= 1'b0;
        end else if (i_ena && i_load) begin
            r_amp     <= i_amp;
            r_has_amp <= w_has_amp;
        end
    end

    // Bypass on load so the first output of a token leaves on its accept edge.
    assign o_type    = w_type;
    assign o_amp     = i_load ? i_amp : r_amp;
    assign o_has_amp = i_load ? w_has_amp : r_has_amp;

endmodule

// File: rtl/jpeg_rld.sv
// JPEG run-length decoder: expands (rlen,size,amp) tokens into BLOCK_LEN zig-zag coefficients.
// Define JPEG_RLD_ERR_EN to drive the err pulse; otherwise err is tied low.
module jpeg_rld
    import jpeg_rld_pkg::*;
#(
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int DW        = 11,
    parameter int AW        = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ena,
    input  logic          i_den,
    input  logic          i_bstart,
    input  logic [3:0]    i_rlen,
    input  logic [3:0]    i_size,
    input  logic [AW-1:0] i_amp,
    output logic          o_rdy,
    output logic [DW-1:0] o_dout,
    output logic          o_dval,
    output logic          o_dstrb,
    output logic          o_dlast,
    output logic          o_err
);

    localparam int            IW   = $clog2(BLOCK_LEN);
    localparam int            CW   = (IW + 1 > 5) ? IW + 1 : 5;
    localparam logic [IW-1:0] LAST = IW'(BLOCK_LEN - 1);

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx, w_base, w_eidx;
    logic [CW-1:0] r_run, w_cnt, w_space, w_eff, w_left;
    logic          r_full;
    logic [DW-1:0] r_dout;
    logic          r_dval, r_dstrb, r_dlast;
    logic [2:0]    w_type_raw;
    tok_t          w_type;
    logic [DW-1:0] w_amp;
    logic          w_has_amp, w_accept, w_drop, w_trunc, w_emit, w_last;

    assign o_rdy    = (r_state == IDLE) || (r_state == COEF);
    assign w_accept = i_ena && i_den && o_rdy;

    jpeg_rld_tok #(.DW(DW)) u_tok (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ena     (i_ena),
        .i_load    (w_accept),
        .i_bstart  (i_bstart),
        .i_rlen    (i_rlen),
        .i_size    (i_size),
        .i_amp     (i_amp[DW-1:0]),
        .i_trunc   (w_trunc),
        .o_type    (w_type_raw),
        .o_amp     (w_amp),
        .o_has_amp (w_has_amp)
    );

    assign w_type  = tok_t'(w_type_raw);
    assign w_drop  = (r_state == IDLE) && (w_type != DC);
    assign w_base  = (w_type == DC) ? '0 : r_idx;
    assign w_space = CW'(BLOCK_LEN) - CW'(w_base);
    assign w_trunc = w_cnt > w_space;
    assign w_eff   = w_trunc ? w_space : w_cnt;

    // Number of outputs the incoming token owes, amplitude included.
    always_comb begin
        w_cnt = '0;
        case (w_type)
            DC, AC, BAD: w_cnt = CW'(i_rlen) + CW'(1);
            ZRL:         w_cnt = CW'(16);
            EOB:         w_cnt = w_space;
            default:     w_cnt = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else if (i_ena) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_emit) begin
            if (w_last)             w_state_nxt = IDLE;
            else if (w_left == '0)  w_state_nxt = COEF;
            else if (w_accept)      w_state_nxt = (w_type == EOB) ? FILL : RUN;
        end
    end

    // Output decode: a freshly accepted token emits on its own edge; otherwise RUN/FILL drain.
    always_comb begin
        w_emit = 1'b0;
        w_eidx = r_idx;
        w_left = r_run;
        if (w_accept && !w_drop) begin
            w_emit = 1'b1;
            w_eidx = w_base;
            w_left = w_eff - CW'(1);
        end else if (!w_accept && ((r_state == RUN) || (r_state == FILL))) begin
            w_emit = 1'b1;
            w_left = r_run - CW'(1);
        end
        w_last = w_emit && (w_eidx == LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_idx   <= '0;
            r_run   <= '0;
            r_full  <= 1'b0;
            r_dout  <= '0;
            r_dval  <= 1'b0;
            r_dstrb <= 1'b0;
            r_dlast <= 1'b0;
        end else if (i_ena) begin
            if (w_emit) begin
                r_idx <= w_eidx + IW'(1);
                r_run <= w_left;
            end
            // A block that filled without an EOB may still see its trailing EOB.
            if (w_last)        r_full <= w_accept ? (w_type != EOB) : (r_state != FILL);
            else if (w_accept) r_full <= 1'b0;
            r_dval  <= w_emit;
            r_dout  <= (w_emit && w_has_amp && (w_left == '0)) ? w_amp : '0;
            r_dstrb <= w_emit && (w_eidx == '0);
            r_dlast <= w_last;
        end
    end

    assign o_dout  = r_dout;
    assign o_dval  = r_dval;
    assign o_dstrb = r_dstrb;
    assign o_dlast = r_dlast;

`ifdef JPEG_RLD_ERR_EN
    logic w_amp_bad, w_err, r_err;
    assign w_amp_bad = ((w_type == DC) || (w_type == AC)) &&
                       (i_amp[AW-1:DW] != {(AW-DW){i_amp[DW-1]}});
    assign w_err = w_accept && ((w_drop && !((w_type == EOB) && r_full)) || (w_type == BAD) ||
                                ((w_type == DC) && (r_state == COEF)) ||
                                (w_trunc && !w_drop) || w_amp_bad);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_err <= 1'b0;
        else if (i_ena) r_err <= w_err;
    end
    assign o_err = r_err;
`else
    logic w_unused;
    assign w_unused = ^{i_amp[AW-1:DW], r_full};
    assign o_err    = 1'b0;
`endif

endmodule
